// File: rtl/jt1943_dwnld.sv
`default_nettype none
//==============================================================================
// Module      : jt1943_dwnld
// Description : ROM download router. Turns each ioctl byte into a masked
//               16-bit SDRAM write (graphics region word-swizzled) or a
//               one-hot on-chip PROM write strobe, runs the SDRAM write
//               handshake, flags overruns and signals end of download.
//               Optional macro JT1943_DWNLD_CHKSUM_EN adds a 16-bit
//               running checksum of accepted bytes.
// Revision    : 1.0 - initial release
//==============================================================================
module jt1943_dwnld #(
    parameter logic [21:0] SND_START  = 22'h1_8000,
    parameter logic [21:0] GFX_START  = 22'h2_0000,
    parameter logic [21:0] PROM_START = 22'h3_8000,
    parameter int          PROM_N     = 8
) (
    input  logic              clk_rom,
    input  logic              rst,
    input  logic              downloading,
    input  logic [21:0]       ioctl_addr,
    input  logic [7:0]        ioctl_data,
    input  logic              ioctl_wr,
    input  logic              sdram_ack,
    output logic [21:0]       prog_addr,
    output logic [7:0]        prog_data,
    output logic [1:0]        prog_mask,
    output logic              prog_we,
    output logic [PROM_N-1:0] prom_we,
    output logic [7:0]        prom_addr,
    output logic              dwnld_done,
    output logic              overrun,
    output logic [15:0]       chksum
);

    // Region bases expressed as word / page indices (bases are aligned)
    localparam logic [20:0] c_snd_word  = SND_START[21:1];
    localparam logic [20:0] c_gfx_word  = GFX_START[21:1];
    localparam logic [13:0] c_prom_page = PROM_START[21:8];
    localparam logic [13:0] c_prom_n    = 14'(PROM_N);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_dl_q;
    logic               r_done_pend;

    logic               w_in_prom;
    logic               w_in_gfx;
    logic               w_in_snd;
    logic [20:0]        w_lin_base;
    logic [20:0]        w_lin_word;
    logic [20:0]        w_gfx_off;
    logic [20:0]        w_gfx_swz;
    logic [20:0]        w_gfx_word;
    logic [20:0]        w_word;
    logic [1:0]         w_mask;
    logic [13:0]        w_page;
    logic               w_page_ok;
    logic [PROM_N-1:0]  w_prom_hot;
    logic               w_wr;
    logic               w_accept;
    logic               w_rise;
    logic               w_fall;

    // Region decode, address remapping and byte-lane mask
    always_comb begin
        w_in_prom  = (ioctl_addr >= PROM_START);
        w_in_gfx   = (ioctl_addr >= GFX_START) && !w_in_prom;
        w_in_snd   = (ioctl_addr >= SND_START) && (ioctl_addr < GFX_START);
        // Main and sound CPU ROMs share the same linear word mapping
        w_lin_base = w_in_snd ? c_snd_word : 21'd0;
        w_lin_word = w_lin_base + (ioctl_addr[21:1] - w_lin_base);
        // Graphics: move word-offset bit 4 down to the LSB
        w_gfx_off  = ioctl_addr[21:1] - c_gfx_word;
        w_gfx_swz  = {w_gfx_off[20:5], w_gfx_off[3:0], w_gfx_off[4]};
        w_gfx_word = c_gfx_word + w_gfx_swz;
        w_word     = w_in_gfx ? w_gfx_word : w_lin_word;
        // Even byte lands in the low lane; mask bit set = lane untouched
        w_mask     = ioctl_addr[0] ? 2'b01 : 2'b10;
        w_page     = ioctl_addr[21:8] - c_prom_page;
        w_page_ok  = (w_page < c_prom_n);
        w_prom_hot = PROM_N'(1) << w_page;
        w_wr       = ioctl_wr & downloading;
        w_accept   = (r_state == S_IDLE) && w_wr && (!w_in_prom || w_page_ok);
        w_rise     = downloading & ~r_dl_q;
        w_fall     = ~downloading & r_dl_q;
    end

    // Write sequencer: routes bytes, holds SDRAM request until ack
    always_ff @(posedge clk_rom) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dl_q      <= 1'b0;
            r_done_pend <= 1'b0;
            prog_addr   <= 22'd0;
            prog_data   <= 8'd0;
            prog_mask   <= 2'b11;
            prog_we     <= 1'b0;
            prom_we     <= '0;
            prom_addr   <= 8'd0;
            dwnld_done  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            r_dl_q     <= downloading;
            prom_we    <= '0;
            dwnld_done <= 1'b0;
            if (w_rise) begin
                overrun <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        dwnld_done <= 1'b1;
                    end
                    if (w_accept) begin
                        if (w_in_prom) begin
                            prom_we   <= w_prom_hot;
                            prom_addr <= ioctl_addr[7:0];
                        end else begin
                            prog_addr <= {1'b0, w_word};
                            prog_data <= ioctl_data;
                            prog_mask <= w_mask;
                            prog_we   <= 1'b1;
                            r_state   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // A byte arriving now cannot be stored; the request in flight is kept
                    if (w_wr) begin
                        overrun <= 1'b1;
                    end
                    if (w_fall) begin
                        r_done_pend <= 1'b1;
                    end
                    if (sdram_ack) begin
                        prog_we <= 1'b0;
                        r_state <= S_IDLE;
                        if (w_fall || r_done_pend) begin
                            dwnld_done  <= 1'b1;
                            r_done_pend <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef JT1943_DWNLD_CHKSUM_EN
    logic [15:0] r_chksum;

    // Wrap-around sum of accepted bytes, restarted by each new download
    always_ff @(posedge clk_rom) begin
        if (rst) begin
            r_chksum <= 16'd0;
        end else if (w_rise) begin
            r_chksum <= w_accept ? {8'd0, ioctl_data} : 16'd0;
        end else if (w_accept) begin
            r_chksum <= r_chksum + {8'd0, ioctl_data};
        end
    end

    assign chksum = r_chksum;
`else
    assign chksum = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jt1943_dwnld.sv
`default_nettype none
//==============================================================================
// Module      : tb_jt1943_dwnld
// Description : Directed self-checking bench for jt1943_dwnld.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_jt1943_dwnld;

    logic        clk_rom = 1'b0;
    logic        rst;
    logic        downloading;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        sdram_ack;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic [7:0]  prom_we;
    logic [7:0]  prom_addr;
    logic        dwnld_done;
    logic        overrun;
    logic [15:0] chksum;

    int          checks = 0;
    int          passes = 0;
    logic [15:0] exp_sum = 16'd0;

    always #5 clk_rom = ~clk_rom;

    jt1943_dwnld dut (
        .clk_rom     (clk_rom),
        .rst         (rst),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_data  (ioctl_data),
        .ioctl_wr    (ioctl_wr),
        .sdram_ack   (sdram_ack),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .prog_we     (prog_we),
        .prom_we     (prom_we),
        .prom_addr   (prom_addr),
        .dwnld_done  (dwnld_done),
        .overrun     (overrun),
        .chksum      (chksum)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [15:0] exp_chk();
`ifdef JT1943_DWNLD_CHKSUM_EN
        return exp_sum;
`else
        return 16'd0;
`endif
    endfunction

    task automatic cyc();
        @(posedge clk_rom);
        #1;
    endtask

    task automatic wr(input logic [21:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        cyc();
        ioctl_wr   = 1'b0;
    endtask

    task automatic ack();
        sdram_ack = 1'b1;
        cyc();
        sdram_ack = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_addr"},  prog_addr, 22'd0);
        check({tag, "_data"},  prog_data, 8'd0);
        check({tag, "_mask"},  prog_mask, 2'b11);
        check({tag, "_we"},    prog_we, 1'b0);
        check({tag, "_promwe"}, prom_we, 8'd0);
        check({tag, "_proma"}, prom_addr, 8'd0);
        check({tag, "_done"},  dwnld_done, 1'b0);
        check({tag, "_ovr"},   overrun, 1'b0);
        check({tag, "_chk"},   chksum, 16'd0);
    endtask

    initial begin
        rst = 1'b1; downloading = 1'b0; ioctl_addr = '0; ioctl_data = '0;
        ioctl_wr = 1'b0; sdram_ack = 1'b0;
        cyc(); cyc();
        check_reset("rst");
        rst = 1'b0;
        downloading = 1'b1;
        cyc();

        // Odd main-ROM byte, handshake
        wr(22'h0_0003, 8'hA5); exp_sum += 16'hA5;
        check("a5_we", prog_we, 1'b1);
        check("a5_addr", prog_addr, 22'h0_0001);
        check("a5_mask", prog_mask, 2'b01);
        check("a5_data", prog_data, 8'hA5);
        check("a5_chk", chksum, exp_chk());
        cyc(); cyc();
        check("a5_hold", prog_we, 1'b1);
        ack();
        check("a5_ackdrop", prog_we, 1'b0);
        ack();
        check("idle_ack", prog_we, 1'b0);

        // Linear regions and boundaries
        wr(22'h0_0010, 8'h3C); exp_sum += 16'h3C;
        check("even_addr", prog_addr, 22'h0_0008);
        check("even_mask", prog_mask, 2'b10);
        ack();
        wr(22'h1_8001, 8'h5A); exp_sum += 16'h5A;
        check("snd_addr", prog_addr, 22'h0_C000);
        check("snd_mask", prog_mask, 2'b01);
        ack();
        wr(22'h1_FFFF, 8'h01); exp_sum += 16'h01;
        check("pregfx_addr", prog_addr, 22'h0_FFFF);
        ack();

        // Graphics swizzle
        wr(22'h2_0000, 8'h02); exp_sum += 16'h02;
        check("gfx0_addr", prog_addr, 22'h1_0000);
        check("gfx0_mask", prog_mask, 2'b10);
        ack();
        wr(22'h2_0020, 8'h03); exp_sum += 16'h03;
        check("gfx16_addr", prog_addr, 22'h1_0001);
        ack();
        wr(22'h2_0002, 8'h04); exp_sum += 16'h04;
        check("gfx1_addr", prog_addr, 22'h1_0002);
        ack();

        // PROM region
        wr(22'h3_8205, 8'hC3); exp_sum += 16'hC3;
        check("prom2_we", prom_we, 8'b0000_0100);
        check("prom2_addr", prom_addr, 8'h05);
        check("prom2_progwe", prog_we, 1'b0);
        cyc();
        check("prom2_pulse", prom_we, 8'd0);
        wr(22'h3_8000, 8'h07); exp_sum += 16'h07;
        check("prom0_we", prom_we, 8'b0000_0001);
        check("prom0_addr", prom_addr, 8'h00);
        wr(22'h3_8805, 8'h99);
        check("prom8_drop", prom_we, 8'd0);
        check("prom8_addr", prom_addr, 8'h00);
        check("prom8_progwe", prog_we, 1'b0);
        check("sum1", chksum, exp_chk());

        // Overrun
        wr(22'h0_0100, 8'h11); exp_sum += 16'h11;
        check("ovr_req", prog_we, 1'b1);
        wr(22'h0_0102, 8'h22);
        check("ovr_flag", overrun, 1'b1);
        check("ovr_data", prog_data, 8'h11);
        check("ovr_addr", prog_addr, 22'h0_0080);
        check("ovr_chk", chksum, exp_chk());
        ack();
        check("ovr_ack", prog_we, 1'b0);
        cyc();
        check("ovr_noextra", prog_we, 1'b0);
        check("ovr_sticky", overrun, 1'b1);

        // Write with downloading low ignored; idle fall pulses done
        downloading = 1'b0;
        wr(22'h0_0004, 8'h66);
        check("nodl_we", prog_we, 1'b0);
        check("idle_done", dwnld_done, 1'b1);
        cyc();
        check("idle_done_end", dwnld_done, 1'b0);
        check("ovr_keep", overrun, 1'b1);
        downloading = 1'b1;
        cyc(); exp_sum = 16'd0;
        check("ovr_clear", overrun, 1'b0);
        check("sum_clear", chksum, exp_chk());

        // Fall while a request is pending
        wr(22'h0_0200, 8'h44); exp_sum += 16'h44;
        downloading = 1'b0;
        cyc();
        check("defer0", dwnld_done, 1'b0);
        check("defer_we", prog_we, 1'b1);
        cyc();
        check("defer1", dwnld_done, 1'b0);
        ack();
        check("defer_done", dwnld_done, 1'b1);
        check("defer_wedrop", prog_we, 1'b0);
        cyc();
        check("defer_once", dwnld_done, 1'b0);

        // Reset mid-request
        downloading = 1'b1;
        cyc(); exp_sum = 16'd0;
        wr(22'h0_0006, 8'h55);
        check("rreq_we", prog_we, 1'b1);
        downloading = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        check_reset("midrst");
        rst = 1'b0;
        sdram_ack = 1'b1;
        cyc();
        sdram_ack = 1'b0;
        check("rst_nodone0", dwnld_done, 1'b0);
        check("rst_we", prog_we, 1'b0);
        cyc();
        check("rst_nodone1", dwnld_done, 1'b0);

        // 257 bytes of 0xFF into PROM 0
        downloading = 1'b1;
        cyc();
        for (int i = 0; i < 257; i++) begin
            wr(22'h3_8000 + 22'(i % 256), 8'hFF);
        end
`ifdef JT1943_DWNLD_CHKSUM_EN
        check("sum_ff", chksum, 16'hFFFF);
`else
        check("sum_ff", chksum, 16'h0000);
`endif
        check("ff_proma", prom_addr, 8'h00);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
